uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares one UART transmit line between NREQ byte requesters.
//   Round-robin arbiter selects a requester and accepts its byte via valid/ready.
//   Framer sends the byte as 8N1: start 0, 8 data bits LSB first, stop 1.
//   Sits between on-chip byte sources (debug, status, echo) and the pin.
// PARAMETERS
//   BAUD  9600      line bit rate, bits/s
//   F     50000000  clk frequency, Hz
//   NREQ  2         number of requesters, 1..8
//   CPB   F/BAUD    derived localparam, clk cycles per bit (integer div), must be >=2
// PORTS
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous, active-low reset
//   req_valid   in   NREQ    requester i has a byte to send
//   req_data    in   8*NREQ  byte of requester i at [8*i+7:8*i]
//   req_ready   out  NREQ    one-hot; byte of requester i accepted this cycle
//   tx          out  1       serial line, idle high
//   busy        out  1       frame in progress (START, DATA or STOP)
//   grant_id    out  3       index of last accepted requester
//   frame_done  out  1       1-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, tx=1, busy=0, grant_id=0,
//     frame_done=0, rr_ptr=0, bit/cycle counters=0. req_ready forced 0.
//   States: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: tx=1. Winner = first i with req_valid[i]=1, searching
//     rr_ptr, rr_ptr+1, ... mod NREQ.
//   req_ready[winner] = 1 combinationally, only in IDLE with rst=1. No valid: no ready.
//   Accept edge (valid & ready): latch byte into shift reg, grant_id<=winner,
//     rr_ptr<=(winner+1) mod NREQ, state<=START, tx<=0, busy<=1.
//   START: tx=0 for CPB cycles, then DATA.
//   DATA: bit k (k=0..7, LSB first) held on tx for CPB cycles each.
//     After bit 7, go to STOP.
//   STOP: tx=1 for CPB cycles.
//     frame_done=1 on the last cycle; next edge: IDLE, busy<=0.
//   tx, busy, frame_done are registered; no glitches on tx.
//   Latency: tx falls on the accept edge. One frame = 10*CPB cycles.
//     Back-to-back frames are 10*CPB+1 cycles apart (one IDLE cycle for arbitration).
//   During busy: req_ready=0. req_valid/req_data are ignored and may change freely.
//   Requester protocol: hold valid and data stable until ready.
//     Dropping valid before ready withdraws the request; this is legal.
//   Cycle counter counts 0..CPB-1 and wraps. Bit counter counts 0..7.
//     There is no other wrap-around.
//   Reset mid-frame: the frame is aborted at once; tx=1 asynchronously.
//     The byte is lost, and the next grant restarts from rr_ptr=0.
//   NREQ=1: degenerates to a simple valid/ready UART TX.
// TESTING (bench: F=1000, BAUD=100 -> CPB=10, NREQ=2 unless noted)
//   1. req_valid=01, data0=0xA5 -> one ready[0] pulse;
//      tx = 0,1,0,1,0,0,1,0,1,1, each 10 cycles;
//      frame_done at cycle 100 after accept; busy high 100 cycles.
//   2. After reset, valid=11 (0x11, 0x22) -> req0 served first, then req1
//      the accept edge after IDLE; grant_id 0 then 1; accepts 101 cycles apart.
//   3. valid=11 held for 4 frames -> grant order 0,1,0,1; no starvation.
//   4. rst low at cycle 45 of a frame -> tx=1, busy=0 without a clock edge;
//      after release, valid=10 -> ready[1] next IDLE cycle; a clean full frame follows.
//   5. req1 valid rises while busy -> ready stays 0 until IDLE;
//      accepted 1 cycle after frame_done.
//   6. NREQ=4, only req1 and req3 valid -> order 1,3,1,3 (rr_ptr wraps 3->0);
//      req valid pulsed and dropped in the same cycle before ready -> no accept.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Byte request bus between NREQ on-chip sources and the UART TX scheduler.
// Requester i presents its byte on req_data[8*i+7:8*i]; req_ready is one-hot.
interface uart_tx_scheduler_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between NREQ byte sources.
// A byte is accepted only in IDLE, so back-to-back frames are 10*CPB+1 cycles apart.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, arbitrate, accept winner's byte
// S_START | start bit (0) for CPB cycles
// S_DATA  | 8 data bits, LSB first, CPB cycles each
// S_STOP  | stop bit (1) for CPB cycles, frame_done on its last cycle
module uart_tx_scheduler #(
  parameter int BAUD = 9600,
  parameter int F    = 50000000,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_tx_scheduler_if.slave        req_if,
  output logic                      tx,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      frame_done
);

  localparam int CPB = F / BAUD;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;

  logic          win_found;
  logic [2:0]    win_idx;
  logic [2:0]    rr_next;
  logic [7:0]    win_data;
  logic          cyc_last;
  logic          cyc_prelast;

  assign cyc_last    = (cyc_cnt == CW'(CPB - 1));
  assign cyc_prelast = (cyc_cnt == CW'(CPB - 2));

  // Winner is the valid requester with the smallest distance from rr_ptr.
  always_comb begin
    int best_d;
    int d;
    int n;
    best_d    = NREQ;
    d         = 0;
    n         = 0;
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_data  = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NREQ;
      if (req_if.req_valid[i] && (d < best_d)) begin
        best_d    = d;
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) win_data = req_if.req_data[8*i +: 8];
    end
    n = int'(win_idx) + 1;
    if (n >= NREQ) n = 0;
    rr_next = 3'(n);
  end

  always_comb begin
    req_if.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_if.req_ready[i] = rst && (state == S_IDLE) && win_found && (win_idx == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= 3'd0;
      frame_done <= 1'b0;
      rr_ptr     <= 3'd0;
      cyc_cnt    <= '0;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (win_found) begin
            shift_q  <= win_data;
            grant_id <= win_idx;
            rr_ptr   <= rr_next;
            state    <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            cyc_cnt  <= '0;
            bit_cnt  <= 3'd0;
          end
        end
        S_START: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= S_DATA;
            tx      <= shift_q[0];
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              state   <= S_STOP;
              tx      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            // Registered, so raise it one edge early to land on the last stop cycle.
            if (cyc_prelast) frame_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: CPB=10, one NREQ=2 and one NREQ=4 instance.
// Expected frames, grant orders and spacings are hand-derived constants.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NREQ(2)) if2 ();
  uart_tx_scheduler_if #(.NREQ(4)) if4 ();

  logic       tx2, busy2, fd2;
  logic [2:0] gid2;
  logic       tx4, busy4, fd4;
  logic [2:0] gid4;

  uart_tx_scheduler #(.BAUD(100), .F(1000), .NREQ(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .req_if     (if2),
    .tx         (tx2),
    .busy       (busy2),
    .grant_id   (gid2),
    .frame_done (fd2)
  );

  uart_tx_scheduler #(.BAUD(100), .F(1000), .NREQ(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .req_if     (if4),
    .tx         (tx4),
    .busy       (busy4),
    .grant_id   (gid4),
    .frame_done (fd4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_acc = 0;
  int acc4_idx[$];

  always @(negedge clk) begin
    if (rst && |(if4.req_valid & if4.req_ready)) begin
      for (int i = 0; i < 4; i++) if (if4.req_ready[i]) acc4_idx.push_back(i);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the grant, then checks the whole frame on the NREQ=2 instance.
  task automatic run_frame(input string tag, input int exp_idx, input logic [7:0] exp_byte,
                           input logic [1:0] after_valid, input int exp_gap);
    logic [9:0] fr;
    bit got;
    fr  = {1'b1, exp_byte, 1'b0};
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = |if2.req_ready;
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_ready"}, 32'(if2.req_ready), 32'd1 << exp_idx);
    @(posedge clk); #1;
    if (exp_gap > 0) check({tag, "_gap"}, cyc - last_acc, exp_gap);
    last_acc = cyc;
    if2.req_valid = after_valid;
    check({tag, "_grant"}, 32'(gid2), exp_idx);
    check({tag, "_busy_start"}, 32'(busy2), 32'd1);
    for (int j = 0; j < 10; j++) begin
      repeat ((j == 0) ? 5 : 10) @(posedge clk);
      #1;
      check($sformatf("%s_bit%0d", tag, j), 32'(tx2), 32'(fr[j]));
      check($sformatf("%s_noready%0d", tag, j), 32'(if2.req_ready), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 check({tag, "_fd_early"}, 32'(fd2), 32'd0);
    @(posedge clk); #1;
    check({tag, "_fd"}, 32'(fd2), 32'd1);
    check({tag, "_busy_last"}, 32'(busy2), 32'd1);
    @(posedge clk); #1;
    check({tag, "_fd_end"}, 32'(fd2), 32'd0);
    check({tag, "_busy_end"}, 32'(busy2), 32'd0);
    check({tag, "_tx_idle"}, 32'(tx2), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    if2.req_valid = 2'b01;
    if2.req_data  = '0;
    if4.req_valid = '0;
    if4.req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx2), 32'd1);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_grant", 32'(gid2), 32'd0);
    check("rst_fd", 32'(fd2), 32'd0);
    check("rst_ready", 32'(if2.req_ready), 32'd0);
    if2.req_valid = 2'b00;
    rst = 1'b1;

    // Single requester, 0xA5
    repeat (2) @(posedge clk); #1;
    if2.req_data  = 16'h00A5;
    if2.req_valid = 2'b01;
    run_frame("t1", 0, 8'hA5, 2'b00, 0);
    repeat (5) @(posedge clk); #1;
    check("t1_idle_noready", 32'(if2.req_ready), 32'd0);

    // Both valid after reset: 0,1,0,1 each 101 cycles apart
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    if2.req_data  = 16'h2211;
    if2.req_valid = 2'b11;
    run_frame("t2a", 0, 8'h11, 2'b11, 0);
    run_frame("t2b", 1, 8'h22, 2'b11, 101);
    run_frame("t3c", 0, 8'h11, 2'b11, 101);
    run_frame("t3d", 1, 8'h22, 2'b00, 101);

    // req1 rises while busy, served right after the frame
    repeat (3) @(posedge clk); #1;
    if2.req_data  = 16'hC33C;
    if2.req_valid = 2'b01;
    run_frame("t5a", 0, 8'h3C, 2'b10, 0);
    run_frame("t5b", 1, 8'hC3, 2'b00, 101);

    // Reset at cycle 45 of a frame (data bit 3 of 0xA5 is 0)
    repeat (3) @(posedge clk); #1;
    if2.req_data  = 16'h96A5;
    if2.req_valid = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = |if2.req_ready;
    end
    if (!got) check("t4_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    repeat (44) @(posedge clk);
    #2;
    check("t4_tx_before", 32'(tx2), 32'd0);
    check("t4_busy_before", 32'(busy2), 32'd1);
    rst = 1'b0;
    #1;
    check("t4_tx_async", 32'(tx2), 32'd1);
    check("t4_busy_async", 32'(busy2), 32'd0);
    check("t4_ready_in_rst", 32'(if2.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    if2.req_valid = 2'b11;
    run_frame("t4a", 0, 8'hA5, 2'b10, 0);
    run_frame("t4b", 1, 8'h96, 2'b00, 101);

    // NREQ=4, only req1 and req3 valid
    if4.req_data  = 32'h44332211;
    if4.req_valid = 4'b1010;
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge clk);
      got = (acc4_idx.size() >= 4);
    end
    if (!got) check("t6_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if4.req_valid = 4'b0000;
    if (acc4_idx.size() >= 4) begin
      check("t6_order0", acc4_idx[0], 1);
      check("t6_order1", acc4_idx[1], 3);
      check("t6_order2", acc4_idx[2], 1);
      check("t6_order3", acc4_idx[3], 3);
    end
    check("t6_grant", 32'(gid4), 32'd3);
    repeat (20) @(posedge clk); #1;
    if4.req_valid = 4'b0001;
    @(posedge clk); #1;
    if4.req_valid = 4'b0000;
    repeat (120) @(posedge clk); #1;
    check("t6_pulse_noacc", acc4_idx.size(), 4);
    check("t6_busy_idle", 32'(busy4), 32'd0);
    check("t6_tx_idle", 32'(tx4), 32'd1);
    check("t6_grant_kept", 32'(gid4), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
